// File: rtl/golf_ball_engine.sv
// golf_ball_engine
//   Multi-player golf game logic. It holds N_BALLS ball positions and advances
//   only the active ball, once per frame_tick. Players alternate through
//   AIM -> ROLL -> AIM, and the turn passes when the ball stops. A ball that
//   comes to rest slowly enough inside the finish zone ends the game (DONE).
//
// Ports
//   pixel_clk, rst          clock; asynchronous active-high reset
//   frame_tick              one-cycle step strobe, the only time state moves
//   restart                 synchronous return to reset state (beats frame_tick)
//   shoot, aim_x, aim_y     fire request and signed launch velocity
//   coll_x, coll_y          map collision flags for the active ball (tick cycle)
//   ball_x_flat/ball_y_flat ball i at [i*COORD_W +: COORD_W]
//   active_ball             index of the ball in play
//   state                   0=AIM, 1=ROLL, 2=DONE
//   ball_idle, victory      high in AIM / high in DONE
//   shots_flat              saturating per-ball shot counters
//   winner                  ball that finished
module golf_ball_engine #(
    parameter int N_BALLS          = 2,
    parameter int COORD_W          = 10,
    parameter int SPEED_W          = 6,
    parameter int SHOT_W           = 4,
    parameter int H_MAX            = 799,
    parameter int V_MAX            = 599,
    parameter int START_X          = 200,
    parameter int START_Y          = 500,
    parameter int FINISH_X         = 600,
    parameter int FINISH_Y         = 500,
    parameter int FINISH_R2        = 400,
    parameter int STOP_SPEED2      = 36,
    parameter int FRAMES_PER_DECEL = 5,
    parameter int DECEL            = 1,
    localparam int AW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1
) (
    input  logic                         pixel_clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic                         restart,
    input  logic                         shoot,
    input  logic signed [SPEED_W-1:0]    aim_x,
    input  logic signed [SPEED_W-1:0]    aim_y,
    input  logic                         coll_x,
    input  logic                         coll_y,
    output logic [N_BALLS*COORD_W-1:0]   ball_x_flat,
    output logic [N_BALLS*COORD_W-1:0]   ball_y_flat,
    output logic [AW-1:0]                active_ball,
    output logic [1:0]                   state,
    output logic                         ball_idle,
    output logic [N_BALLS*SHOT_W-1:0]    shots_flat,
    output logic                         victory,
    output logic [AW-1:0]                winner
);

    // PW: position arithmetic with room for sign and overflow past the bound.
    // VW: speed arithmetic with room for negation/step without wrapping.
    localparam int PW = COORD_W + 2;
    localparam int VW = SPEED_W + 2;
    localparam int DW = 2 * COORD_W + 1;
    localparam int QW = 2 * SPEED_W + 1;
    localparam int CW = (FRAMES_PER_DECEL > 1) ? $clog2(FRAMES_PER_DECEL) : 1;

    localparam logic signed [VW-1:0] SMAX     = VW'(2 ** (SPEED_W - 1) - 1);
    localparam logic signed [VW-1:0] DECEL_C  = VW'(DECEL);
    localparam logic signed [PW-1:0] HMAX_C   = PW'(H_MAX);
    localparam logic signed [PW-1:0] VMAX_C   = PW'(V_MAX);
    localparam logic signed [PW-1:0] FX_C     = PW'(FINISH_X);
    localparam logic signed [PW-1:0] FY_C     = PW'(FINISH_Y);
    localparam logic [COORD_W-1:0]   SX_C     = COORD_W'(START_X);
    localparam logic [COORD_W-1:0]   SY_C     = COORD_W'(START_Y);
    localparam logic [DW-1:0]        R2_C     = DW'(FINISH_R2);
    localparam logic [QW-1:0]        STOP2_C  = QW'(STOP_SPEED2);
    localparam logic [CW-1:0]        CNT_LAST = CW'(FRAMES_PER_DECEL - 1);
    localparam logic [AW-1:0]        ACT_LAST = AW'(N_BALLS - 1);

    typedef enum logic [1:0] {
        AIM  = 2'd0,
        ROLL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                             st;
    logic [N_BALLS-1:0][COORD_W-1:0]    pos_x;
    logic [N_BALLS-1:0][COORD_W-1:0]    pos_y;
    logic [N_BALLS-1:0][SHOT_W-1:0]     shots;
    // Only the active ball can be moving, so one velocity register is enough.
    logic signed [SPEED_W-1:0]          vx;
    logic signed [SPEED_W-1:0]          vy;
    logic [CW-1:0]                      dcnt;

    // ------------------------------------------------------------------
    // helpers
    // ------------------------------------------------------------------
    function automatic logic signed [VW-1:0] ext(input logic signed [SPEED_W-1:0] v);
        return VW'(v);
    endfunction

    // Clamp to +/-SMAX; this also maps the most negative aim code to -SMAX.
    function automatic logic signed [SPEED_W-1:0] sat(input logic signed [VW-1:0] v);
        logic signed [VW-1:0] r;
        if (v > SMAX)
            r = SMAX;
        else if (v < -SMAX)
            r = -SMAX;
        else
            r = v;
        return r[SPEED_W-1:0];
    endfunction

    function automatic logic signed [VW-1:0] fric(input logic signed [VW-1:0] v);
        logic signed [VW-1:0] r;
        if (v <= DECEL_C && v >= -DECEL_C)
            r = '0;
        else if (v[VW-1])
            r = v + DECEL_C;
        else
            r = v - DECEL_C;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // one ROLL step for the active ball
    // ------------------------------------------------------------------
    logic [COORD_W-1:0]        cur_x, cur_y;
    logic signed [VW-1:0]      vx_r, vy_r, vx_m, vy_m, vx_f, vy_f;
    logic signed [PW-1:0]      sum_x, sum_y, x_m, y_m, dx, dy;
    logic [PW-1:0]             adx, ady;
    logic [VW-1:0]             avx, avy;
    logic [DW-1:0]             dist2;
    logic [QW-1:0]             spd2;
    logic                      in_zone, fric_en, slow;
    logic signed [SPEED_W-1:0] vx_n, vy_n, aim_vx, aim_vy;
    logic [CW-1:0]             dcnt_n;
    logic [AW-1:0]             act_n;

    always_comb begin
        cur_x = pos_x[active_ball];
        cur_y = pos_y[active_ball];

        // reflect off map walls
        vx_r = coll_x ? -ext(vx) : ext(vx);
        vy_r = coll_y ? -ext(vy) : ext(vy);

        // move, bouncing off the screen edges
        sum_x = $signed({2'b00, cur_x}) + PW'(vx_r);
        sum_y = $signed({2'b00, cur_y}) + PW'(vy_r);
        x_m  = sum_x;
        vx_m = vx_r;
        if (sum_x[PW-1]) begin
            x_m  = '0;
            vx_m = -vx_r;
        end else if (sum_x > HMAX_C) begin
            x_m  = HMAX_C;
            vx_m = -vx_r;
        end
        y_m  = sum_y;
        vy_m = vy_r;
        if (sum_y[PW-1]) begin
            y_m  = '0;
            vy_m = -vy_r;
        end else if (sum_y > VMAX_C) begin
            y_m  = VMAX_C;
            vy_m = -vy_r;
        end

        // distance to the finish at the new position
        dx    = x_m - FX_C;
        dy    = y_m - FY_C;
        adx   = dx[PW-1] ? PW'(-dx) : PW'(dx);
        ady   = dy[PW-1] ? PW'(-dy) : PW'(dy);
        dist2 = DW'(adx) * DW'(adx) + DW'(ady) * DW'(ady);
        in_zone = dist2 < R2_C;

        // inside the zone the green is "sticky": friction every frame
        fric_en = (dcnt == '0) || in_zone;
        vx_f = fric_en ? fric(vx_m) : vx_m;
        vy_f = fric_en ? fric(vy_m) : vy_m;
        vx_n = sat(vx_f);
        vy_n = sat(vy_f);

        avx  = vx_n[SPEED_W-1] ? VW'(-ext(vx_n)) : VW'(ext(vx_n));
        avy  = vy_n[SPEED_W-1] ? VW'(-ext(vy_n)) : VW'(ext(vy_n));
        spd2 = QW'(avx) * QW'(avx) + QW'(avy) * QW'(avy);
        slow = spd2 < STOP2_C;

        dcnt_n = (dcnt == CNT_LAST) ? '0 : dcnt + 1'b1;
        act_n  = (active_ball == ACT_LAST) ? '0 : active_ball + 1'b1;

        aim_vx = sat(ext(aim_x));
        aim_vy = sat(ext(aim_y));
    end

    // ------------------------------------------------------------------
    // game FSM and state registers
    // ------------------------------------------------------------------
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            st          <= AIM;
            pos_x       <= {N_BALLS{SX_C}};
            pos_y       <= {N_BALLS{SY_C}};
            shots       <= '0;
            vx          <= '0;
            vy          <= '0;
            dcnt        <= '0;
            active_ball <= '0;
            ball_idle   <= 1'b1;
            victory     <= 1'b0;
            winner      <= '0;
        end else if (restart) begin
            st          <= AIM;
            pos_x       <= {N_BALLS{SX_C}};
            pos_y       <= {N_BALLS{SY_C}};
            shots       <= '0;
            vx          <= '0;
            vy          <= '0;
            dcnt        <= '0;
            active_ball <= '0;
            ball_idle   <= 1'b1;
            victory     <= 1'b0;
            winner      <= '0;
        end else if (frame_tick) begin
            case (st)
                AIM: begin
                    if (shoot) begin
                        vx        <= aim_vx;
                        vy        <= aim_vy;
                        dcnt      <= '0;
                        st        <= ROLL;
                        ball_idle <= 1'b0;
                        if (shots[active_ball] != '1)
                            shots[active_ball] <= shots[active_ball] + 1'b1;
                    end
                end
                ROLL: begin
                    pos_x[active_ball] <= x_m[COORD_W-1:0];
                    pos_y[active_ball] <= y_m[COORD_W-1:0];
                    vx   <= vx_n;
                    vy   <= vy_n;
                    dcnt <= dcnt_n;
                    if (in_zone && slow) begin
                        st      <= DONE;
                        victory <= 1'b1;
                        winner  <= active_ball;
                    end else if (vx_n == '0 && vy_n == '0) begin
                        // a zero-aim shot lands here on its first tick
                        st          <= AIM;
                        ball_idle   <= 1'b1;
                        active_ball <= act_n;
                    end
                end
                default: ; // DONE holds until reset/restart
            endcase
        end
    end

    assign state       = st;
    assign ball_x_flat = pos_x;
    assign ball_y_flat = pos_y;
    assign shots_flat  = shots;

endmodule
